// File: rtl/deparser_avlstrm_if.sv
// Packet/metadata stream bundle for the deparser: metadata-in, flit-in and flit-out.
// slave is the deparser side, master the upstream/downstream side.
interface deparser_avlstrm_if #(
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6,
    parameter int META_W  = 512
);
    logic [META_W-1:0]  in_meta_data;
    logic               in_meta_valid;
    logic               in_meta_ready;

    logic [DATA_W-1:0]  in_pkt_data;
    logic               in_pkt_valid;
    logic               in_pkt_sop;
    logic               in_pkt_eop;
    logic [EMPTY_W-1:0] in_pkt_empty;
    logic               in_pkt_ready;

    logic [DATA_W-1:0]  out_pkt_data;
    logic               out_pkt_valid;
    logic               out_pkt_sop;
    logic               out_pkt_eop;
    logic [EMPTY_W-1:0] out_pkt_empty;
    logic [META_W-1:0]  out_pkt_meta;
    logic               out_pkt_ready;

    modport slave (
        input  in_meta_data, in_meta_valid,
        output in_meta_ready,
        input  in_pkt_data, in_pkt_valid, in_pkt_sop, in_pkt_eop, in_pkt_empty,
        output in_pkt_ready,
        output out_pkt_data, out_pkt_valid, out_pkt_sop, out_pkt_eop, out_pkt_empty, out_pkt_meta,
        input  out_pkt_ready
    );

    modport master (
        output in_meta_data, in_meta_valid,
        input  in_meta_ready,
        output in_pkt_data, in_pkt_valid, in_pkt_sop, in_pkt_eop, in_pkt_empty,
        input  in_pkt_ready,
        input  out_pkt_data, out_pkt_valid, out_pkt_sop, out_pkt_eop, out_pkt_empty, out_pkt_meta,
        output out_pkt_ready
    );
endinterface

// File: rtl/deparser_avlstrm.sv
// Rejoins one metadata record per packet with its flit stream, drops flagged packets,
// and emits the packet through a 2-entry registered skid buffer with metadata sideband.
module deparser_avlstrm #(
    parameter int DATA_W   = 512,
    parameter int EMPTY_W  = 6,
    parameter int META_W   = 512,
    parameter int DROP_BIT = 0
) (
    input  logic        Clk,
    input  logic        Rst_n,
    deparser_avlstrm_if.slave bus,
    output logic [31:0] stats_out_pkt,
    output logic [31:0] stats_drop,
    output logic [31:0] stats_err
);
    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    typedef struct packed {
        logic [META_W-1:0]  meta;
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } entry_t;

    state_t            r_state, w_state_nxt;
    logic [META_W-1:0] r_meta;
    logic              r_first;
    entry_t            r_out, r_skid, w_in_entry;
    logic [1:0]        r_cnt, w_cnt_nxt;
    logic              r_out_vld;
    logic [31:0]       r_stats_out_pkt, r_stats_drop, r_stats_err;

    logic w_accept, w_bad_first, w_bad_sop, w_pkt_end, w_push, w_pop;

    // Ready depends only on state and buffer occupancy, never on out_pkt_ready.
    assign bus.in_pkt_ready = (r_state == DROP) || ((r_state == FWD) && (r_cnt != 2'd2));

    assign w_accept    = bus.in_pkt_valid && bus.in_pkt_ready;
    assign w_bad_first = w_accept && r_first && !bus.in_pkt_sop;
    assign w_bad_sop   = w_accept && !r_first && bus.in_pkt_sop;
    assign w_pkt_end   = w_accept && bus.in_pkt_eop && !w_bad_first;
    assign w_push      = w_accept && (r_state == FWD) && !w_bad_first;
    assign w_pop       = r_out_vld && bus.out_pkt_ready;

    assign bus.in_meta_ready = w_pkt_end;

    always_comb begin
        w_in_entry       = '0;
        w_in_entry.meta  = r_meta;
        w_in_entry.data  = bus.in_pkt_data;
        w_in_entry.sop   = bus.in_pkt_sop && r_first;
        w_in_entry.eop   = bus.in_pkt_eop;
        w_in_entry.empty = bus.in_pkt_eop ? bus.in_pkt_empty : '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (bus.in_meta_valid)
                      w_state_nxt = bus.in_meta_data[DROP_BIT] ? DROP : FWD;
            FWD:  if (w_pkt_end) w_state_nxt = IDLE;
            DROP: if (w_pkt_end) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
            r_meta  <= '0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && bus.in_meta_valid) begin
                r_meta  <= bus.in_meta_data;
                r_first <= 1'b1;
            end else if (w_accept && !w_bad_first) begin
                r_first <= 1'b0;
            end
        end
    end

    assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

    // r_out is the presented head; r_skid only fills when a push meets a stalled head.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt     <= 2'd0;
            r_out_vld <= 1'b0;
            r_out     <= '0;
            r_skid    <= '0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_out_vld <= (w_cnt_nxt != 2'd0);
            case (r_cnt)
                2'd0: if (w_push) r_out <= w_in_entry;
                2'd1: begin
                    if (w_push && w_pop) r_out  <= w_in_entry;
                    else if (w_push)     r_skid <= w_in_entry;
                end
                default: if (w_pop) r_out <= r_skid;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_stats_out_pkt <= '0;
            r_stats_drop    <= '0;
            r_stats_err     <= '0;
        end else begin
            if (w_pop)                          r_stats_out_pkt <= r_stats_out_pkt + 32'd1;
            if (w_pkt_end && (r_state == DROP)) r_stats_drop    <= r_stats_drop + 32'd1;
            if (w_bad_first || w_bad_sop)       r_stats_err     <= r_stats_err + 32'd1;
        end
    end

    assign bus.out_pkt_data  = r_out.data;
    assign bus.out_pkt_valid = r_out_vld;
    assign bus.out_pkt_sop   = r_out.sop;
    assign bus.out_pkt_eop   = r_out.eop;
    assign bus.out_pkt_empty = r_out.empty;
    assign bus.out_pkt_meta  = r_out.meta;

    assign stats_out_pkt = r_stats_out_pkt;
    assign stats_drop    = r_stats_drop;
    assign stats_err     = r_stats_err;
endmodule

// File: tb/tb_deparser_avlstrm.sv
// Directed bench for deparser_avlstrm: stimulus pushes expected flits into a queue,
// a negedge monitor pops and compares every accepted output flit.
module tb_deparser_avlstrm;
    localparam int DATA_W  = 512;
    localparam int EMPTY_W = 6;
    localparam int META_W  = 512;

    typedef struct packed {
        logic [META_W-1:0]  meta;
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } flit_t;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [31:0] st_out, st_drop, st_err;

    deparser_avlstrm_if #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .META_W(META_W)) bus ();

    deparser_avlstrm #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .META_W(META_W), .DROP_BIT(0)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .bus(bus),
        .stats_out_pkt(st_out), .stats_drop(st_drop), .stats_err(st_err)
    );

    always #5 Clk = ~Clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc_cnt  = 0;
    int          pulses   = 0;
    int          exp_pulses = 0;
    bit          lat_chk  = 1'b0;
    flit_t       exp_q[$];
    int          acc_q[$];
    logic [META_W-1:0] cur_meta;

    always @(posedge Clk) cyc_cnt++;

    task automatic cmp32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cmp_flit(input string name, input flit_t act, input flit_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got tag %h sop %b eop %b empty %0d meta %h, want tag %h sop %b eop %b empty %0d meta %h",
                     name, act.data[31:0], act.sop, act.eop, act.empty, act.meta[31:0],
                     exp.data[31:0], exp.sop, exp.eop, exp.empty, exp.meta[31:0]);
        end
    endtask

    // Monitor: checks hold-stability under backpressure and pops the scoreboard on transfers.
    flit_t mon_prev;
    bit    mon_hold = 1'b0;
    always @(negedge Clk) begin
        flit_t cur, e;
        int    acc;
        cur.meta  = bus.out_pkt_meta;
        cur.data  = bus.out_pkt_data;
        cur.sop   = bus.out_pkt_sop;
        cur.eop   = bus.out_pkt_eop;
        cur.empty = bus.out_pkt_empty;
        if (!Rst_n) begin
            mon_hold = 1'b0;
        end else begin
            if (mon_hold) cmp_flit("hold_stable", cur, mon_prev);
            if (bus.out_pkt_valid && bus.out_pkt_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_flit: got tag %h, want none", cur.data[31:0]);
                end else begin
                    e = exp_q.pop_front();
                    cmp_flit("out_flit", cur, e);
                    if (lat_chk && acc_q.size() != 0) begin
                        acc = acc_q.pop_front();
                        cmp32("latency", cyc_cnt + 1, acc + 1);
                    end
                end
            end
            mon_hold = bus.out_pkt_valid && !bus.out_pkt_ready;
            mon_prev = cur;
            if (bus.in_meta_ready) pulses++;
        end
    end

    task automatic start_meta(input logic [31:0] m);
        cur_meta          = {16{m}};
        bus.in_meta_data  = {16{m}};
        bus.in_meta_valid = 1'b1;
    endtask

    // Drives one flit, waits (bounded) for acceptance, returns at posedge+1.
    task automatic send_flit(input logic [31:0] tag, input logic sop, input logic eop,
                             input logic [EMPTY_W-1:0] emp, input bit exp_out, input bit exp_sop);
        flit_t f;
        int    w = 0;
        bus.in_pkt_valid = 1'b1;
        bus.in_pkt_data  = {16{tag}};
        bus.in_pkt_sop   = sop;
        bus.in_pkt_eop   = eop;
        bus.in_pkt_empty = emp;
        if (exp_out) begin
            f.meta  = cur_meta;
            f.data  = {16{tag}};
            f.sop   = exp_sop;
            f.eop   = eop;
            f.empty = eop ? emp : '0;
            exp_q.push_back(f);
        end
        if (eop) exp_pulses++;
        @(negedge Clk);
        while (!bus.in_pkt_ready && w < 50) begin
            @(negedge Clk);
            w++;
        end
        if (!bus.in_pkt_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept for tag %h, want accept within 50 cycles", tag);
        end else if (exp_out && lat_chk) begin
            acc_q.push_back(cyc_cnt + 1);
        end
        @(posedge Clk);
        #1;
        if (eop) begin
            bus.in_pkt_valid  = 1'b0;
            bus.in_meta_valid = 1'b0;
        end
    endtask

    task automatic send_pkt(input logic [31:0] m, input logic [31:0] base, input int n,
                            input logic [EMPTY_W-1:0] emp, input bit exp_out);
        start_meta(m);
        for (int i = 0; i < n; i++)
            send_flit(base + i, i == 0, i == n - 1, emp, exp_out, i == 0);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge Clk);
            w++;
        end
        repeat (3) @(posedge Clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d flits pending, want 0", exp_q.size());
            exp_q.delete();
        end
        acc_q.delete();
    endtask

    initial begin
        int p0;
        bus.in_meta_data  = '0;
        bus.in_meta_valid = 1'b0;
        bus.in_pkt_data   = '0;
        bus.in_pkt_valid  = 1'b0;
        bus.in_pkt_sop    = 1'b0;
        bus.in_pkt_eop    = 1'b0;
        bus.in_pkt_empty  = '0;
        bus.out_pkt_ready = 1'b1;

        // Reset state
        #12;
        cmp32("rst_out_valid", {31'd0, bus.out_pkt_valid}, 32'd0);
        cmp32("rst_in_pkt_ready", {31'd0, bus.in_pkt_ready}, 32'd0);
        cmp32("rst_in_meta_ready", {31'd0, bus.in_meta_ready}, 32'd0);
        cmp32("rst_stats", st_out | st_drop | st_err, 32'd0);
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        repeat (2) @(posedge Clk);
        #1;

        // Forward A: 3 flits, empty=5, 1-cycle latency, consecutive outputs
        lat_chk = 1'b1;
        send_pkt(32'hA000_0000, 32'hD000_0000, 3, 6'd5, 1'b1);
        drain();
        cmp32("t1_stats_out", st_out, 32'd3);
        cmp32("t1_pulses", pulses, 32'd1);

        // Dropped B (4 flits) then single-flit C
        p0 = pulses;
        send_pkt(32'hB000_0001, 32'hB100_0000, 4, 6'd3, 1'b0);
        send_pkt(32'hC000_0000, 32'hC100_0000, 1, 6'd7, 1'b1);
        drain();
        lat_chk = 1'b0;
        cmp32("t2_stats_drop", st_drop, 32'd1);
        cmp32("t2_stats_out", st_out, 32'd4);
        cmp32("t2_pulses", pulses - p0, 32'd2);

        // Backpressure: out_pkt_ready low for 5 cycles during a 6-flit packet
        bus.out_pkt_ready = 1'b0;
        fork
            send_pkt(32'h3000_0000, 32'h3100_0000, 6, 6'd1, 1'b1);
            begin
                repeat (4) @(posedge Clk);
                @(negedge Clk);
                cmp32("t3_in_ready_full", {31'd0, bus.in_pkt_ready}, 32'd0);
                cmp32("t3_out_valid", {31'd0, bus.out_pkt_valid}, 32'd1);
                @(posedge Clk);
                #1 bus.out_pkt_ready = 1'b1;
            end
        join
        drain();
        cmp32("t3_stats_out", st_out, 32'd10);

        // Framing: leading non-sop flit discarded, mid-packet sop cleared
        start_meta(32'h4000_0000);
        send_flit(32'h4100_0000, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        send_flit(32'h4100_0001, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1);
        send_flit(32'h4100_0002, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
        send_flit(32'h4100_0003, 1'b0, 1'b1, 6'd9, 1'b1, 1'b0);
        drain();
        cmp32("t4_stats_err", st_err, 32'd2);
        cmp32("t4_stats_out", st_out, 32'd13);

        // Async reset mid-packet (flit 2 of 4 presented, first two buffered)
        bus.out_pkt_ready = 1'b0;
        start_meta(32'h5000_0000);
        send_flit(32'h5100_0000, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        send_flit(32'h5100_0001, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        bus.in_pkt_data = {16{32'h5100_0002}};
        bus.in_pkt_sop  = 1'b0;
        @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        cmp32("t5_out_valid", {31'd0, bus.out_pkt_valid}, 32'd0);
        cmp32("t5_out_sop_eop", {30'd0, bus.out_pkt_sop, bus.out_pkt_eop}, 32'd0);
        cmp32("t5_out_data", bus.out_pkt_data[31:0], 32'd0);
        cmp32("t5_out_meta", bus.out_pkt_meta[31:0], 32'd0);
        cmp32("t5_in_ready", {30'd0, bus.in_pkt_ready, bus.in_meta_ready}, 32'd0);
        cmp32("t5_stats_out", st_out, 32'd0);
        cmp32("t5_stats_err_drop", st_err | st_drop, 32'd0);
        bus.in_pkt_valid  = 1'b0;
        bus.in_meta_valid = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;
        bus.out_pkt_ready = 1'b1;
        @(posedge Clk);
        #1;
        send_pkt(32'h6000_0000, 32'h6100_0000, 2, 6'd2, 1'b1);
        drain();
        cmp32("t5_post_stats_out", st_out, 32'd2);
        cmp32("t5_post_stats_err", st_err, 32'd0);

        // Counter wrap
        @(negedge Clk);
        force dut.r_stats_out_pkt = 32'hFFFF_FFFE;
        #1 release dut.r_stats_out_pkt;
        @(posedge Clk);
        #1;
        send_pkt(32'h7000_0000, 32'h7100_0000, 3, 6'd0, 1'b1);
        drain();
        cmp32("t6_wrap", st_out, 32'h0000_0001);

        cmp32("meta_pulses_total", pulses, exp_pulses);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, want finish before 200us");
        $fatal(1);
    end
endmodule
